// File: rtl/vpu_pkg.sv
// Shared vector-unit constants, FSM encoding and vlen clamp helper.
package vpu_pkg;

    localparam int VEC_LANES = 8;
    localparam int ELEM_W    = 8;
    localparam int VLEN_W    = 4;
    localparam int VEC_W     = 64;

    localparam logic MODE_ELEM = 1'b0;
    localparam logic MODE_DOT  = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Requests longer than the lane count process every lane.
    function automatic logic [VLEN_W-1:0] clamp_vlen(input logic [VLEN_W-1:0] v);
        return (v > VLEN_W'(VEC_LANES)) ? VLEN_W'(VEC_LANES) : v;
    endfunction

endpackage

// File: rtl/vec_mul_sequencer_if.sv
// Request/result handshake bundle for vec_mul_sequencer.
interface vec_mul_sequencer_if;
    import vpu_pkg::*;

    logic              start_valid;
    logic              start_ready;
    logic [VEC_W-1:0]  op_a;
    logic [VEC_W-1:0]  op_b;
    logic [VLEN_W-1:0] vlen;
    logic              mode;
    logic              res_valid;
    logic              res_ready;
    logic [VEC_W-1:0]  result;
    logic              busy;

    modport master (
        output start_valid, op_a, op_b, vlen, mode, res_ready,
        input  start_ready, res_valid, result, busy
    );

    modport slave (
        input  start_valid, op_a, op_b, vlen, mode, res_ready,
        output start_ready, res_valid, result, busy
    );

endinterface

// File: rtl/vec_mul_sequencer_mult.sv
// Signed 8x8 multiplier keeping only the upper byte of the 16-bit product.
module truncated_multiplier_8bit
    import vpu_pkg::*;
(
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic [ELEM_W-1:0] p
);

    logic signed [2*ELEM_W-1:0] full;

    always_comb begin
        full = $signed(a) * $signed(b);
        p    = full[2*ELEM_W-1:ELEM_W];
    end

endmodule

// File: rtl/vec_mul_sequencer.sv
// Sequences one shared truncating multiplier across up to eight byte lanes,
// producing either a packed element-wise product or a byte dot-accumulate.
module vec_mul_sequencer
    import vpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    vec_mul_sequencer_if.slave bus
);

    logic [1:0]        state;
    logic [2:0]        idx;
    logic [VLEN_W-1:0] len_r;
    logic              mode_r;
    logic [VEC_W-1:0]  a_r;
    logic [VEC_W-1:0]  b_r;
    logic [VEC_W-1:0]  result_r;
    logic [ELEM_W-1:0] elem_a;
    logic [ELEM_W-1:0] elem_b;
    logic [ELEM_W-1:0] prod_hi;
    logic [VLEN_W-1:0] vlen_c;

    always_comb begin
        elem_a = a_r[{idx, 3'b000} +: ELEM_W];
        elem_b = b_r[{idx, 3'b000} +: ELEM_W];
        vlen_c = clamp_vlen(bus.vlen);
    end

    truncated_multiplier_8bit u_mult (
        .a (elem_a),
        .b (elem_b),
        .p (prod_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            len_r    <= '0;
            mode_r   <= MODE_ELEM;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_valid) begin
                        a_r      <= bus.op_a;
                        b_r      <= bus.op_b;
                        len_r    <= vlen_c;
                        mode_r   <= bus.mode;
                        idx      <= '0;
                        result_r <= '0;
                        state    <= (vlen_c == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Untouched bytes stay zero because the accept cleared them.
                    if (mode_r == MODE_DOT)
                        result_r[ELEM_W-1:0] <= result_r[ELEM_W-1:0] + prod_hi;
                    else
                        result_r[{idx, 3'b000} +: ELEM_W] <= prod_hi;
                    idx <= idx + 3'd1;
                    if ({1'b0, idx} == len_r - 4'd1)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.res_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.start_ready = (state == ST_IDLE);
        bus.busy        = (state != ST_IDLE);
        bus.res_valid   = (state == ST_DONE);
        bus.result      = result_r;
    end

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Self-checking bench: directed vectors, hold/reset corner cases and
// randomized back-to-back traffic against an arithmetic reference model.
module tb_vec_mul_sequencer;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    vec_mul_sequencer_if bus();

    vec_mul_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  vlen;
        logic        mode;
        logic [63:0] exp_res;
        int          exp_edges;
        string       name;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
        end
    endtask

    // Reference: upper byte of each signed product, stored per lane or summed mod 256.
    function automatic logic [63:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [3:0] vl, input logic m);
        int n;
        int acc;
        logic [63:0] r;
        n   = (vl > 8) ? 8 : int'(vl);
        acc = 0;
        r   = '0;
        for (int i = 0; i < n; i++) begin
            byte ea;
            byte eb;
            int  prod;
            int  p;
            ea   = a[8*i +: 8];
            eb   = b[8*i +: 8];
            prod = ea * eb;
            p    = (prod >>> 8) & 255;
            if (m) acc = (acc + p) % 256;
            else   r[8*i +: 8] = p[7:0];
        end
        if (m) r[7:0] = acc[7:0];
        return r;
    endfunction

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] vl,
                          input logic m, input logic [63:0] exp_r, input int exp_e,
                          input int hold_n, input string nm);
        int k;
        @(negedge clk);
        chk({nm, ".start_ready"}, 64'(bus.start_ready), 64'd1);
        bus.op_a        = a;
        bus.op_b        = b;
        bus.vlen        = vl;
        bus.mode        = m;
        bus.start_valid = 1'b1;
        bus.res_ready   = 1'b0;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        bus.op_a        = {$urandom, $urandom};
        bus.op_b        = {$urandom, $urandom};
        bus.vlen        = 4'($urandom);
        bus.mode        = 1'($urandom);
        k = 1;
        while (!bus.res_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({nm, ".latency"}, 64'(k), 64'(exp_e));
        chk({nm, ".result"}, bus.result, exp_r);
        for (int h = 0; h < hold_n; h++) begin
            @(negedge clk);
            bus.start_valid = 1'($urandom);
            @(posedge clk);
            #1;
            chk({nm, ".hold_valid"}, 64'(bus.res_valid), 64'd1);
            chk({nm, ".hold_result"}, bus.result, exp_r);
            chk({nm, ".hold_start_ready"}, 64'(bus.start_ready), 64'd0);
        end
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b1;
        @(posedge clk);
        #1;
        chk({nm, ".handoff_valid"}, 64'(bus.res_valid), 64'd0);
        chk({nm, ".handoff_ready"}, 64'(bus.start_ready), 64'd1);
        chk({nm, ".retained"}, bus.result, exp_r);
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] ra, rb, er;
        logic [3:0]  rv;
        logic        rm;
        int          n, k;

        tbl[0] = '{64'h1122_3344_FF80_7F40, 64'h5566_7788_0180_7F04, 4'd4, 1'b0,
                   64'h0000_0000_FF40_3F01, 5, "elem_vlen4"};
        tbl[1] = '{64'h7F7F_7F7F_7F40_4040, 64'h7F7F_7F7F_7F0C_0804, 4'd3, 1'b1,
                   64'h0000_0000_0000_0006, 4, "dot_vlen3"};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8080_8080_8080_8080, 4'd0, 1'b0,
                   64'h0, 1, "vlen0"};
        tbl[3] = '{64'h4040_4040_4040_4040, 64'h0404_0404_0404_0404, 4'd12, 1'b0,
                   64'h0101_0101_0101_0101, 9, "elem_vlen12"};
        tbl[4] = '{64'h4040_4040_4040_4040, 64'h4040_4040_4040_4040, 4'd8, 1'b1,
                   64'h0000_0000_0000_0080, 9, "dot_vlen8"};
        tbl[5] = '{64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080, 4'd15, 1'b1,
                   64'h0, 9, "dot_wrap"};

        rst_n           = 1'b0;
        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b0;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.vlen        = '0;
        bus.mode        = 1'b0;
        #1;
        chk("reset.start_ready", 64'(bus.start_ready), 64'd1);
        chk("reset.busy", 64'(bus.busy), 64'd0);
        chk("reset.res_valid", 64'(bus.res_valid), 64'd0);
        chk("reset.result", bus.result, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++)
            run_op(tbl[t].a, tbl[t].b, tbl[t].vlen, tbl[t].mode,
                   tbl[t].exp_res, tbl[t].exp_edges, 0, tbl[t].name);

        run_op(tbl[0].a, tbl[0].b, tbl[0].vlen, tbl[0].mode,
               tbl[0].exp_res, tbl[0].exp_edges, 5, "hold_done");

        // Asynchronous reset while the index sits at 2.
        @(negedge clk);
        bus.op_a        = {$urandom, $urandom};
        bus.op_b        = {$urandom, $urandom};
        bus.vlen        = 4'd8;
        bus.mode        = 1'b0;
        bus.start_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_run.res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_run.busy", 64'(bus.busy), 64'd0);
        chk("rst_run.start_ready", 64'(bus.start_ready), 64'd1);
        chk("rst_run.result", bus.result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_run.no_partial", 64'(bus.res_valid), 64'd0);
        run_op(tbl[1].a, tbl[1].b, tbl[1].vlen, tbl[1].mode,
               tbl[1].exp_res, tbl[1].exp_edges, 0, "after_reset");

        // Back-to-back with start_valid and res_ready held high.
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.res_ready   = 1'b1;
        for (int op = 0; op < 24; op++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rv = 4'($urandom_range(0, 15));
            rm = 1'($urandom);
            er = ref_model(ra, rb, rv, rm);
            n  = (rv > 8) ? 8 : int'(rv);
            bus.op_a = ra;
            bus.op_b = rb;
            bus.vlen = rv;
            bus.mode = rm;
            chk("b2b.start_ready", 64'(bus.start_ready), 64'd1);
            @(posedge clk);
            #1;
            k = 1;
            while (!bus.res_valid && k < 20) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("b2b.latency", 64'(k), 64'(n + 1));
            chk("b2b.result", bus.result, er);
            @(posedge clk);
            #1;
            chk("b2b.handoff_valid", 64'(bus.res_valid), 64'd0);
            chk("b2b.handoff_busy", 64'(bus.busy), 64'd0);
            @(negedge clk);
        end
        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
